instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Fetch front-end that feeds the IF/ID pipeline register.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory using a req/ack handshake.
- Buffers returned instructions with their PCs in a small FIFO.
- Presents the FIFO head to IF/ID, and is stalled by the hazard unit's IF/ID write enable and flushed by a taken branch from EX/MEM.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- XLEN, 32, instruction and PC width.
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  word address of the request (fetch_pc).
- imem_ack  in  1  memory accepted the request and returns data this cycle.
- imem_rdata  in  XLEN  instruction word, valid when imem_ack=1.
- redirect_valid  in  1  taken branch (ex_mem_Branch & ex_mem_zero).
- redirect_pc  in  XLEN  branch target (ex_mem_pc).
- deq_ready  in  1  IF/ID write enable from the hazard unit (if_idWrite).
- out_valid  out  1  FIFO head is valid.
- out_instr  out  XLEN  FIFO head instruction; 32'h0000_0013 (NOP) when out_valid=0.
- out_pc  out  XLEN  PC of the FIFO head; 0 when out_valid=0.

Behaviour:
- Reset (rst=1 at edge):
  - fetch_pc=RESET_PC; FIFO emptied (count=0, rd_ptr=wr_ptr=0); FSM=IDLE.
  - Outputs: imem_req=0, out_valid=0, out_instr=NOP, out_pc=0.
  - Reset mid-transaction abandons any outstanding request; a late ack is ignored because FSM=IDLE.
- FSM, one outstanding request at most:
  - IDLE: if count<DEPTH and no redirect, go to REQ.
  - REQ: imem_req=1, imem_addr=fetch_pc. imem_addr must stay stable until ack. On imem_ack: write {fetch_pc, imem_rdata} to the FIFO, fetch_pc+=4, then go to REQ if the post-update count<DEPTH, else IDLE.
  - DROP: imem_req=1 with the stale address held. On imem_ack: discard the data and go to REQ.
- Redirect (highest priority, same edge):
  - FIFO flushed (count=0), fetch_pc=redirect_pc.
  - The dequeue this cycle is suppressed.
  - If FSM=REQ and imem_ack=0, go to DROP. If FSM=REQ and imem_ack=1, discard the data and go to REQ.
  - If FSM=DROP and imem_ack=0, stay in DROP. Otherwise go to REQ.
- Issue rule: a request issues only when a slot is free, so an ack never finds the FIFO full. count+outstanding never exceeds DEPTH.
- Dequeue: when out_valid & deq_ready & ~redirect_valid, rd_ptr++ and count--.
  - Simultaneous enqueue and dequeue leaves count unchanged.
- Latency and ordering:
  - Ack at edge N makes the entry visible at the head (out_valid=1) after edge N, with no same-cycle bypass.
  - Pointers wrap modulo DEPTH; order is strict FIFO.
- Width: fetch_pc+4 wraps modulo 2^XLEN. The low 2 bits of redirect_pc are forced to 0.
- deq_ready=0 holds out_valid, out_instr and out_pc stable.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_redirects [15:0], incremented on each cycle with redirect_valid=1.
  - Adds outputs perf_starve [31:0], incremented on each cycle with out_valid=0 & deq_ready=1.
  - Both counters saturate at their maximum and clear on rst.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg:
  - NOP_INSTR=32'h0000_0013.
  - Enum fetch_state_t {IDLE, REQ, DROP}.
  - Typedef fetch_entry_t {pc, instr}.
- Sub-module fetch_fifo:
  - Synchronous FIFO of fetch_entry_t with push, pop, flush, count, head.
  - flush has priority over push and pop.

Test Plan:
- Reset, then imem_ack=1 every cycle and deq_ready=1 -> out_pc sequence 0,4,8,12 on consecutive cycles; first out_valid=1 two cycles after rst deasserts.
- deq_ready=0, ack always 1 -> exactly 4 entries (PCs 0..12) buffered; imem_req drops to 0; out_pc holds at 0.
- Ack delayed 3 cycles -> imem_addr stays constant while imem_req=1; out_valid=0 with out_instr=NOP during starvation.
- redirect_valid with redirect_pc=0x100 while a request is outstanding, ack 2 cycles later -> stale data dropped; next enqueued out_pc=0x100; FIFO empty the cycle after the redirect.
- redirect_valid in the same cycle as imem_ack and out_valid&deq_ready -> ack data discarded, no dequeue, fetch_pc=redirect_pc.
- rst asserted while in DROP, then a late imem_ack -> ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch queue.
//               NOP_INSTR     - instruction presented when the queue is empty
//               fetch_state_t - request FSM states (IDLE, REQ, DROP)
//               fetch_entry_t - one buffered fetch: {pc, instr}
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Width of the pc/instr fields carried in a queue entry.
    localparam int ENTRY_W = 32;

    // addi x0, x0, 0
    localparam logic [ENTRY_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ENTRY_W-1:0] pc;
        logic [ENTRY_W-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of fetch_entry_t. flush empties the queue and
//               overrides push and pop on the same edge. head is the oldest
//               entry (contents undefined while count == 0).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               flush             - discard all entries
//               push, push_entry  - enqueue one entry
//               pop               - dequeue the head
//               count             - number of valid entries (0..DEPTH)
//               head              - oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage needs no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (pop && !push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : Fetch front-end feeding the IF/ID register. Owns the fetch PC,
//               keeps at most one request outstanding to a variable-latency
//               instruction memory (req/ack), buffers {pc, instr} in a FIFO
//               and presents the head. A taken branch flushes the queue and
//               redirects fetch; an in-flight request is then drained (DROP).
//               XLEN must equal fetch_pkg::ENTRY_W.
// Ports       : clk, rst                  - clock, synchronous active-high reset
//               imem_req/imem_addr        - request to instruction memory
//               imem_ack/imem_rdata       - acceptance + returned word
//               redirect_valid/_pc        - taken branch from EX/MEM
//               deq_ready                 - IF/ID write enable
//               out_valid/_instr/_pc      - queue head (NOP / 0 when empty)
//               perf_redirects/perf_starve- saturating counters, present only
//                                           when FETCH_PERF_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            deq_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]     perf_redirects,
    output logic [31:0]     perf_starve
`endif
);

    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [XLEN-1:0]  r_fetch_pc;
    logic [XLEN-1:0]  w_fetch_pc_nxt;
    logic [XLEN-1:0]  r_req_addr;
    logic [XLEN-1:0]  w_redirect_aligned;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_post;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_entry;
    logic             w_push;
    logic             w_pop;
    logic             w_out_valid;

    assign w_redirect_aligned = redirect_pc & ~XLEN'(3);
    assign w_out_valid        = (w_count != '0);
    // A redirect kills both the returning word and this cycle's dequeue.
    assign w_push             = (r_state == REQ) && imem_ack && !redirect_valid;
    assign w_pop              = w_out_valid && deq_ready && !redirect_valid;
    assign w_push_entry       = '{pc: r_fetch_pc, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .count      (w_count),
        .head       (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            // The address is captured only when a fresh request is launched,
            // so it stays put through REQ waits and through DROP.
            if (w_state_nxt == REQ) begin
                r_req_addr <= w_fetch_pc_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_count_post   = w_count;
        imem_req       = (r_state == REQ) || (r_state == DROP);

        if (w_push && !w_pop) begin
            w_count_post = w_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_post = w_count - CNT_W'(1);
        end

        if (redirect_valid) begin
            w_fetch_pc_nxt = w_redirect_aligned;
        end else if (w_push) begin
            w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
        end

        // Issue only into a free slot, so an ack can never meet a full FIFO.
        case (r_state)
            IDLE: begin
                if (redirect_valid || (w_count < C_DEPTH)) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    w_state_nxt = imem_ack ? REQ : DROP;
                end else if (imem_ack) begin
                    w_state_nxt = (w_count_post < C_DEPTH) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign imem_addr = r_req_addr;
    assign out_valid = w_out_valid;
    assign out_instr = w_out_valid ? w_head.instr : NOP_INSTR;
    assign out_pc    = w_out_valid ? w_head.pc : '0;

`ifdef FETCH_PERF_EN
    logic [15:0] r_perf_redirects;
    logic [31:0] r_perf_starve;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_redirects <= '0;
            r_perf_starve    <= '0;
        end else begin
            if (redirect_valid && (r_perf_redirects != '1)) begin
                r_perf_redirects <= r_perf_redirects + 16'd1;
            end
            if (!w_out_valid && deq_ready && (r_perf_starve != '1)) begin
                r_perf_starve <= r_perf_starve + 32'd1;
            end
        end
    end

    assign perf_redirects = r_perf_redirects;
    assign perf_starve    = r_perf_starve;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Self-checking bench for instr_fetch_queue. The expected stream
//               is the program order from the last reset/redirect target
//               (pc, pc+4, ...) with instructions from a fixed memory image
//               function; a monitor pops and compares on every dequeue.
//               Directed scenarios are followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] BAD      = 32'hBAD0_BAD0;

    localparam int M_ALWAYS = 0;
    localparam int M_RAND   = 1;
    localparam int M_DELAY  = 2;
    localparam int M_FORCE  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            deq_ready;
    logic            out_valid;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
`ifdef FETCH_PERF_EN
    logic [15:0]     perf_redirects;
    logic [31:0]     perf_starve;
`endif

    int          n_checks = 0;
    int          n_pass   = 0;
    int          mode     = M_ALWAYS;
    int          delay    = 0;
    logic        force_ack = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_next;

    instr_fetch_queue #(
        .DEPTH          (DEPTH),
        .XLEN           (XLEN),
        .RESET_PC       (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_ready      (deq_ready),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_redirects (perf_redirects),
        .perf_starve    (perf_starve)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory image.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0003;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill();
        while (exp_q.size() < 16) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] base);
        exp_q.delete();
        exp_next = base;
        fill();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!out_valid && k < 50) begin
            step();
            k++;
        end
        check({name, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (!imem_req && k < 50) begin
            step();
            k++;
        end
        check({name, "_timeout"}, 32'(imem_req), 32'd1);
    endtask

    // Memory responder: decides imem_ack for the current cycle.
    initial begin
        int wait_cnt = 0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                M_ALWAYS: imem_ack = imem_req;
                M_RAND:   imem_ack = imem_req && ($urandom_range(0, 2) == 0);
                M_DELAY: begin
                    if (!imem_req) begin
                        imem_ack = 1'b0;
                        wait_cnt = 0;
                    end else if (wait_cnt >= delay) begin
                        imem_ack = 1'b1;
                        wait_cnt = 0;
                    end else begin
                        imem_ack = 1'b0;
                        wait_cnt++;
                    end
                end
                default:  imem_ack = force_ack;
            endcase
            if (mode != M_DELAY) begin
                wait_cnt = 0;
            end
            imem_rdata = (imem_ack && imem_req && mode != M_FORCE) ? mem_word(imem_addr) : BAD;
        end
    end

    // Monitor / scoreboard, sampled mid-cycle.
    initial begin
        logic        p_rst = 1'b1;
        logic        p_valid = 1'b0, p_ready = 1'b0, p_redir = 1'b0;
        logic        p_req = 1'b0, p_ack = 1'b0;
        logic [31:0] p_addr = '0, p_pc = '0, p_instr = '0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (!out_valid) begin
                    check("empty_instr_nop", out_instr, NOP);
                    check("empty_pc_zero", out_pc, 32'd0);
                end
                if (!p_rst && p_req && !p_ack) begin
                    check("req_held", 32'(imem_req), 32'd1);
                    check("addr_stable", imem_addr, p_addr);
                end
                if (!p_rst && p_valid && !p_ready && !p_redir) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_pc", out_pc, p_pc);
                    check("hold_instr", out_instr, p_instr);
                end
                if (out_valid && deq_ready && !redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        check("scoreboard_empty", 32'd0, 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_pc", out_pc, e);
                        check("sb_instr", out_instr, mem_word(e));
                        fill();
                    end
                end
            end
            p_rst   = rst;
            p_valid = out_valid;
            p_ready = deq_ready;
            p_redir = redirect_valid;
            p_req   = imem_req;
            p_ack   = imem_ack;
            p_addr  = imem_addr;
            p_pc    = out_pc;
            p_instr = out_instr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_addr;
        logic [31:0] rp;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        deq_ready      = 1'b0;
        restart(RESET_PC);
        repeat (3) step();

        // Reset state.
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, NOP);
        check("rst_pc", out_pc, 32'd0);

        // Streaming: first valid two edges after reset release.
        rst       = 1'b0;
        deq_ready = 1'b1;
        mode      = M_ALWAYS;
        step();
        check("lat_edge1_valid", 32'(out_valid), 32'd0);
        step();
        check("lat_edge2_valid", 32'(out_valid), 32'd1);
        check("stream_pc0", out_pc, 32'd0);
        for (int i = 1; i < 4; i++) begin
            step();
            check("stream_pc", out_pc, 32'(4 * i));
        end

        // Fill with no dequeue: exactly DEPTH entries, then request stops.
        rst       = 1'b1;
        deq_ready = 1'b0;
        restart(RESET_PC);
        step();
        rst = 1'b0;
        repeat (8) step();
        check("full_req_low", 32'(imem_req), 32'd0);
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_pc_hold", out_pc, 32'd0);
        mode      = M_FORCE;
        force_ack = 1'b0;
        deq_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            check("drain_pc", out_pc, 32'(4 * i));
        end
        step();
        check("drain_empty", 32'(out_valid), 32'd0);
        check("drain_req_addr", imem_addr, 32'd16);

        // Ack delayed by 3 cycles: address stable, NOP while starved.
        mode  = M_DELAY;
        delay = 3;
        for (int i = 0; i < 3; i++) begin
            check("slow_req", 32'(imem_req), 32'd1);
            check("slow_addr", imem_addr, 32'd16);
            check("slow_valid", 32'(out_valid), 32'd0);
            check("slow_nop", out_instr, NOP);
            step();
        end
        step();
        check("slow_arrive_valid", 32'(out_valid), 32'd1);
        check("slow_arrive_pc", out_pc, 32'd16);

        // Redirect while a request is outstanding; late ack is dropped.
        mode      = M_FORCE;
        force_ack = 1'b0;
        deq_ready = 1'b0;
        step();
        wait_req("drop_wait_req");
        old_addr       = imem_addr;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        restart(32'h0000_0100);
        step();
        redirect_valid = 1'b0;
        check("drop_flushed", 32'(out_valid), 32'd0);
        check("drop_req", 32'(imem_req), 32'd1);
        check("drop_stale_addr", imem_addr, old_addr);
        step();
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        check("drop_reissue_addr", imem_addr, 32'h0000_0100);
        check("drop_discarded", 32'(out_valid), 32'd0);
        mode      = M_ALWAYS;
        deq_ready = 1'b1;
        wait_valid("drop_first");
        check("drop_first_pc", out_pc, 32'h0000_0100);

        // Redirect coinciding with ack and a dequeue.
        repeat (4) step();
        begin
            int k = 0;
            while (!(out_valid && imem_req) && k < 50) begin
                step();
                k++;
            end
            check("coinc_setup", 32'(out_valid && imem_req), 32'd1);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        restart(32'h0000_0200);
        step();
        redirect_valid = 1'b0;
        check("coinc_flushed", 32'(out_valid), 32'd0);
        check("coinc_req", 32'(imem_req), 32'd1);
        check("coinc_addr", imem_addr, 32'h0000_0200);
        wait_valid("coinc_first");
        check("coinc_first_pc", out_pc, 32'h0000_0200);

        // Reset while in DROP, then a late ack.
        mode      = M_FORCE;
        force_ack = 1'b0;
        step();
        wait_req("rstdrop_wait_req");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        restart(32'h0000_0300);
        step();
        redirect_valid = 1'b0;
        check("rstdrop_in_drop", 32'(imem_req), 32'd1);
        rst = 1'b1;
        restart(RESET_PC);
        step();
        check("rstdrop_req_low", 32'(imem_req), 32'd0);
        rst       = 1'b0;
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        check("rstdrop_late_ignored", 32'(out_valid), 32'd0);
        check("rstdrop_req", 32'(imem_req), 32'd1);
        check("rstdrop_addr", imem_addr, RESET_PC);
        mode = M_ALWAYS;
        wait_valid("rstdrop_first");
        check("rstdrop_first_pc", out_pc, RESET_PC);
        check("rstdrop_first_instr", out_instr, mem_word(RESET_PC));

        // Randomized traffic.
        mode = M_RAND;
        for (int i = 0; i < 3000; i++) begin
            deq_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 39) == 0);
            rst            = ($urandom_range(0, 299) == 0);
            if (redirect_valid) begin
                rp          = $urandom;
                redirect_pc = rp;
                restart(rp & ~32'd3);
            end
            if (rst) begin
                restart(RESET_PC);
            end
            step();
        end
        rst            = 1'b0;
        redirect_valid = 1'b0;
        deq_ready      = 1'b1;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
